// File: rtl/complex_acc.sv
// complex_acc -- coherent complex accumulator sitting downstream of complex_cal.
// Sums ACC_LEN signed complex samples per frame with per-component saturation
// and presents each completed frame on a valid/ready output register.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high (priority over clr)
//   clr      synchronous flush of partial frame, output stage and overrun flag
//   din_vld  input sample valid (no backpressure)
//   din_re   input real part, signed D_WIDTH
//   din_im   input imag part, signed D_WIDTH
//   acc_vld  frame sum valid, held until accepted
//   acc_rdy  consumer ready; transfer on acc_vld & acc_rdy
//   acc_re   frame sum real, signed A_WIDTH
//   acc_im   frame sum imag, signed A_WIDTH
//   acc_sat  presented frame clamped in re or im
//   acc_ovr  sticky: a completed frame overwrote an unaccepted one
//   cnt      samples accumulated in the current frame
module complex_acc #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 16,
  parameter int ACC_LEN = 16,
  parameter int C_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               din_vld,
  input  logic [D_WIDTH-1:0] din_re,
  input  logic [D_WIDTH-1:0] din_im,
  output logic               acc_vld,
  input  logic               acc_rdy,
  output logic [A_WIDTH-1:0] acc_re,
  output logic [A_WIDTH-1:0] acc_im,
  output logic               acc_sat,
  output logic               acc_ovr,
  output logic [C_WIDTH-1:0] cnt
);

  typedef enum logic {FR_IDLE, FR_ACC} frame_state_t;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  frame_state_t r_frame_state, w_frame_next;
  out_state_t   r_out_state, w_out_next;

  logic [A_WIDTH-1:0] r_run_re, r_run_im;
  logic               r_sat;
  logic [C_WIDTH-1:0] r_cnt;
  logic [A_WIDTH-1:0] r_acc_re, r_acc_im;
  logic               r_acc_sat;
  logic               r_acc_ovr;

  logic [A_WIDTH-1:0] w_sum_re, w_sum_im;
  logic               w_clip_re, w_clip_im;
  logic               w_last;
  logic               w_ovr_set;

  // Returns {clipped, result}: one guard bit detects overflow, which is then
  // replaced by the most positive / most negative representable value.
  function automatic logic [A_WIDTH:0] sat_add(input logic [A_WIDTH-1:0] a,
                                               input logic [D_WIDTH-1:0] b);
    logic [A_WIDTH:0] ext_b;
    logic [A_WIDTH:0] wide;
    logic [A_WIDTH:0] res;
    ext_b = {{(A_WIDTH+1-D_WIDTH){b[D_WIDTH-1]}}, b};
    wide  = {a[A_WIDTH-1], a} + ext_b;
    if (wide[A_WIDTH] != wide[A_WIDTH-1]) begin
      if (wide[A_WIDTH]) res = {1'b1, 1'b1, {(A_WIDTH-1){1'b0}}};
      else               res = {1'b1, 1'b0, {(A_WIDTH-1){1'b1}}};
    end else begin
      res = {1'b0, wide[A_WIDTH-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    {w_clip_re, w_sum_re} = sat_add(r_run_re, din_re);
    {w_clip_im, w_sum_im} = sat_add(r_run_im, din_im);
    w_last    = din_vld && (r_cnt == C_WIDTH'(ACC_LEN - 1));
    w_ovr_set = w_last && (r_out_state == OUT_FULL) && !acc_rdy;

    w_frame_next = r_frame_state;
    unique case (r_frame_state)
      FR_IDLE: if (din_vld) w_frame_next = FR_ACC;
      FR_ACC:  if (w_last)  w_frame_next = FR_IDLE;
      default: w_frame_next = FR_IDLE;
    endcase

    // A completion always leaves the stage FULL: either it was empty, the old
    // frame is transferred this cycle, or the old frame is overwritten.
    w_out_next = r_out_state;
    unique case (r_out_state)
      OUT_EMPTY: if (w_last) w_out_next = OUT_FULL;
      OUT_FULL:  if (!w_last && acc_rdy) w_out_next = OUT_EMPTY;
      default:   w_out_next = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_frame_state <= FR_IDLE;
      r_out_state   <= OUT_EMPTY;
      r_run_re      <= '0;
      r_run_im      <= '0;
      r_sat         <= 1'b0;
      r_cnt         <= '0;
      r_acc_re      <= '0;
      r_acc_im      <= '0;
      r_acc_sat     <= 1'b0;
      r_acc_ovr     <= 1'b0;
    end else begin
      r_frame_state <= w_frame_next;
      r_out_state   <= w_out_next;
      if (din_vld) begin
        if (w_last) begin
          r_acc_re  <= w_sum_re;
          r_acc_im  <= w_sum_im;
          r_acc_sat <= r_sat | w_clip_re | w_clip_im;
          r_run_re  <= '0;
          r_run_im  <= '0;
          r_sat     <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_run_re <= w_sum_re;
          r_run_im <= w_sum_im;
          r_sat    <= r_sat | w_clip_re | w_clip_im;
          r_cnt    <= r_cnt + C_WIDTH'(1);
        end
      end
      if (w_ovr_set) r_acc_ovr <= 1'b1;
    end
  end

  assign acc_vld = (r_out_state == OUT_FULL);
  assign acc_re  = r_acc_re;
  assign acc_im  = r_acc_im;
  assign acc_sat = r_acc_sat;
  assign acc_ovr = r_acc_ovr;
  assign cnt     = r_cnt;

endmodule

// File: tb/tb_complex_acc.sv
// tb_complex_acc -- self-checking bench for complex_acc.
// Two instances share one stimulus stream: a short-frame wide-sum instance
// (ACC_LEN=4, A_WIDTH=16) and a long-frame narrow-sum instance (ACC_LEN=16,
// A_WIDTH=10) that saturates readily. A transaction-level integer model tracks
// both and every cycle is compared, alongside directed constant checks.
module tb_complex_acc;

  logic clk = 1'b0;
  logic rst = 1'b0, clr = 1'b0, din_vld = 1'b0, acc_rdy = 1'b0;
  logic [7:0] din_re = '0, din_im = '0;

  logic              a_vld, a_sat, a_ovr;
  logic signed [15:0] a_re, a_im;
  logic [2:0]        a_cnt;
  logic              b_vld, b_sat, b_ovr;
  logic signed [9:0] b_re, b_im;
  logic [4:0]        b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // model state, index 0 = ACC_LEN 4 / A 16, index 1 = ACC_LEN 16 / A 10
  int c_len[2] = '{4, 16};
  int c_hi[2]  = '{32767, 511};
  int m_re[2], m_im[2], m_cnt[2], m_ore[2], m_oim[2];
  bit m_sat[2], m_full[2], m_osat[2], m_ovr[2];

  always #5 clk = ~clk;

  complex_acc #(.D_WIDTH(8), .A_WIDTH(16), .ACC_LEN(4), .C_WIDTH(3)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .din_vld(din_vld), .din_re(din_re),
    .din_im(din_im), .acc_vld(a_vld), .acc_rdy(acc_rdy), .acc_re(a_re),
    .acc_im(a_im), .acc_sat(a_sat), .acc_ovr(a_ovr), .cnt(a_cnt));

  complex_acc #(.D_WIDTH(8), .A_WIDTH(10), .ACC_LEN(16), .C_WIDTH(5)) u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .din_vld(din_vld), .din_re(din_re),
    .din_im(din_im), .acc_vld(b_vld), .acc_rdy(acc_rdy), .acc_re(b_re),
    .acc_im(b_im), .acc_sat(b_sat), .acc_ovr(b_ovr), .cnt(b_cnt));

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampv(input int x, input int hi, output bit hit);
    hit = 1'b0;
    if (x > hi) begin
      hit = 1'b1;
      return hi;
    end
    if (x < -hi - 1) begin
      hit = 1'b1;
      return -hi - 1;
    end
    return x;
  endfunction

  task automatic model_step(input int k, input bit v, input int re, input int im,
                            input bit rdy, input bit c, input bit r);
    int sr, si;
    bit hr, hi, done;
    done = 1'b0;
    if (r || c) begin
      m_re[k] = 0; m_im[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
      m_full[k] = 0; m_ore[k] = 0; m_oim[k] = 0; m_osat[k] = 0; m_ovr[k] = 0;
    end else begin
      if (v) begin
        sr = clampv(m_re[k] + re, c_hi[k], hr);
        si = clampv(m_im[k] + im, c_hi[k], hi);
        if (m_cnt[k] + 1 == c_len[k]) begin
          if (m_full[k] && !rdy) m_ovr[k] = 1'b1;
          m_full[k] = 1'b1;
          m_ore[k]  = sr;
          m_oim[k]  = si;
          m_osat[k] = m_sat[k] | hr | hi;
          m_re[k] = 0; m_im[k] = 0; m_sat[k] = 0; m_cnt[k] = 0;
          done = 1'b1;
        end else begin
          m_re[k] = sr; m_im[k] = si;
          m_sat[k] = m_sat[k] | hr | hi;
          m_cnt[k]++;
        end
      end
      if (!done && m_full[k] && rdy) m_full[k] = 1'b0;
    end
  endtask

  task automatic cmp_dut(input string p, input int k, input logic v,
                         input logic signed [63:0] re, input logic signed [63:0] im,
                         input logic s, input logic o, input logic [63:0] c);
    check({p, "_vld"}, 64'(v), 64'(m_full[k]));
    check({p, "_ovr"}, 64'(o), 64'(m_ovr[k]));
    check({p, "_cnt"}, c, 64'(m_cnt[k]));
    if (m_full[k]) begin
      check({p, "_re"},  re, 64'(m_ore[k]));
      check({p, "_im"},  im, 64'(m_oim[k]));
      check({p, "_sat"}, 64'(s), 64'(m_osat[k]));
    end
  endtask

  task automatic tick(input bit v, input int re, input int im, input bit rdy,
                      input bit c, input bit r);
    din_vld = v;
    din_re  = re[7:0];
    din_im  = im[7:0];
    acc_rdy = rdy;
    clr     = c;
    rst     = r;
    model_step(0, v, re, im, rdy, c, r);
    model_step(1, v, re, im, rdy, c, r);
    @(posedge clk);
    #1;
    cmp_dut("d4", 0, a_vld, a_re, a_im, a_sat, a_ovr, 64'(a_cnt));
    cmp_dut("d16", 1, b_vld, b_re, b_im, b_sat, b_ovr, 64'(b_cnt));
    @(negedge clk);
  endtask

  task automatic check_zero_all(input string p);
    check({p, "_a_vld"}, 64'(a_vld), 0);
    check({p, "_a_re"},  a_re, 0);
    check({p, "_a_im"},  a_im, 0);
    check({p, "_a_sat"}, 64'(a_sat), 0);
    check({p, "_a_ovr"}, 64'(a_ovr), 0);
    check({p, "_a_cnt"}, 64'(a_cnt), 0);
    check({p, "_b_vld"}, 64'(b_vld), 0);
    check({p, "_b_re"},  b_re, 0);
    check({p, "_b_cnt"}, 64'(b_cnt), 0);
  endtask

  initial begin
    int mag, re, im;
    bit rdy;
    @(negedge clk);

    // reset state
    tick(0, 0, 0, 0, 0, 1);
    check_zero_all("rst0");

    // frame sum with immediate acceptance
    for (int i = 1; i <= 4; i++) tick(1, i, -i, 1, 0, 0);
    check("t1_vld", 64'(a_vld), 1);
    check("t1_re", a_re, 10);
    check("t1_im", a_im, -10);
    check("t1_sat", 64'(a_sat), 0);
    tick(0, 0, 0, 1, 0, 0);
    check("t1_vld_drop", 64'(a_vld), 0);

    // saturation on the narrow instance
    tick(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 16; i++) tick(1, 127, -128, 1, 0, 0);
    check("t2_vld", 64'(b_vld), 1);
    check("t2_re", b_re, 511);
    check("t2_im", b_im, -512);
    check("t2_sat", 64'(b_sat), 1);

    // overwrite of an unaccepted frame
    tick(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 2, 2, 0, 0, 0);
    check("t3_re", a_re, 8);
    check("t3_im", a_im, 8);
    check("t3_ovr", 64'(a_ovr), 1);
    tick(0, 0, 0, 1, 0, 0);
    check("t3_vld_drop", 64'(a_vld), 0);
    check("t3_ovr_sticky", 64'(a_ovr), 1);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("t3_ovr_hold", 64'(a_ovr), 1);
    tick(0, 0, 0, 0, 1, 0);
    check("t3_ovr_clr", 64'(a_ovr), 0);
    check("t3_re_clr", a_re, 0);

    // back-to-back frames, ready only in the second completion cycle
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 0, 0);
    check("t4_vld1", 64'(a_vld), 1);
    check("t4_re1", a_re, 4);
    for (int i = 0; i < 3; i++) tick(1, 3, -1, 0, 0, 0);
    tick(1, 3, -1, 1, 0, 0);
    check("t4_vld2", 64'(a_vld), 1);
    check("t4_re2", a_re, 12);
    check("t4_im2", a_im, -4);
    check("t4_ovr", 64'(a_ovr), 0);
    tick(0, 0, 0, 1, 0, 0);

    // flush mid-frame with a coincident sample
    tick(0, 0, 0, 1, 1, 0);
    tick(1, 7, 7, 1, 0, 0);
    tick(1, 7, 7, 1, 0, 0);
    tick(1, 9, 9, 1, 1, 0);
    check("t5_cnt_clr", 64'(a_cnt), 0);
    for (int i = 0; i < 4; i++) tick(1, 5, 0, 1, 0, 0);
    check("t5_re_clr", a_re, 20);
    check("t5_im_clr", a_im, 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(1, 7, 7, 1, 0, 0);
    tick(1, 7, 7, 1, 0, 0);
    tick(1, 9, 9, 1, 0, 1);
    check_zero_all("t5_rst1");
    tick(1, 9, 9, 1, 0, 1);
    check_zero_all("t5_rst2");
    for (int i = 0; i < 4; i++) tick(1, 5, 0, 1, 0, 0);
    check("t5_re_rst", a_re, 20);
    check("t5_im_rst", a_im, 0);

    // gapped random stream with random consumer ready
    tick(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 1250; i++) begin
      for (int j = 0; j < 5; j++) begin
        rdy = ($urandom_range(0, 3) == 0);
        tick(0, 0, 0, rdy, 0, 0);
      end
      mag = ($urandom_range(0, 1) == 1) ? 127 : 15;
      re  = int'($urandom_range(0, 2 * mag)) - mag;
      im  = int'($urandom_range(0, 2 * mag + 1)) - mag - 1;
      rdy = ($urandom_range(0, 3) == 0);
      tick(1, re, im, rdy, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
